rs_latch_driver: RTL and testbench

- Initiator side for the gated RS latch: accepts set/reset/hold commands, drives the latch R, S and gate-enable with fixed setup/pulse/hold timing, then samples the latch output Q.
- Compares Q against the expected state, flags mismatches and keeps a saturating error count.
- Sits between board switch/command logic and the gate-level latch; used for latch bring-up and self-check on the board.

---
 rtl/rs_latch_driver_if.sv | 73 +++++++
 rtl/rs_latch_driver.sv | 202 ++++++++++++++++++++
 tb/tb_rs_latch_driver.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_latch_driver_if.sv
// ---------------------------------------------------------------------------
// rs_latch_driver_if
//   Bundles the command handshake, the latch drive/sense pins and the
//   result/status signals of rs_latch_driver.
//
//   Handshake: a command transfers on a rising Clk edge where cmd_valid and
//   cmd_ready are both 1. cmd_ready depends on the driver state only, never
//   on cmd_valid. Commands offered while cmd_ready is 0 are not queued; the
//   source must keep cmd_valid and cmd_op stable until the transfer edge.
//
//   slave  : the driver block (consumes commands, drives the latch).
//   master : the command source plus latch (drives commands and latch_q).
//
//   Signals
//     cmd_valid, cmd_op[1:0]   command strobe and opcode (00 hold, 01 set,
//                              10 reset, 11 illegal)
//     cmd_ready                driver idle
//     latch_clk/r/s            gate enable and R/S inputs of the latch
//     latch_q                  latch output, asynchronous to Clk
//     done, match, q_sampled   completion pulse, compare result, sampled Q
//     illegal                  pulse for a rejected op 11
//     err_count[CNT_W-1:0]     saturating mismatch count
//     state_dbg[2:0]           current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
interface rs_latch_driver_if #(
    parameter int CNT_W = 8
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             latch_clk;
    logic             latch_r;
    logic             latch_s;
    logic             latch_q;
    logic             done;
    logic             match;
    logic             q_sampled;
    logic             illegal;
    logic [CNT_W-1:0] err_count;
    logic [2:0]       state_dbg;

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  latch_q,
        output cmd_ready,
        output latch_clk,
        output latch_r,
        output latch_s,
        output done,
        output match,
        output q_sampled,
        output illegal,
        output err_count,
        output state_dbg
    );

    modport master (
        output cmd_valid,
        output cmd_op,
        output latch_q,
        input  cmd_ready,
        input  latch_clk,
        input  latch_r,
        input  latch_s,
        input  done,
        input  match,
        input  q_sampled,
        input  illegal,
        input  err_count,
        input  state_dbg
    );
endinterface

// File: rtl/rs_latch_driver.sv
// ---------------------------------------------------------------------------
// rs_latch_driver
//   Initiator for a gated RS latch. Accepts hold/set/reset commands, drives
//   R/S and the gate enable with fixed setup, pulse and hold timing, waits
//   for the latch output to settle through a 2-flop synchronizer, samples Q
//   and compares it with the expected latch state. Mismatches are counted in
//   a saturating counter.
//
//   Timeline (accept edge ends cycle 0):
//     cycle 1                    SETUP   R/S driven, gate low
//     cycles 2 .. PULSE_W+1      DRIVE   gate high
//     cycle PULSE_W+2            HOLD    gate low, R/S still held
//     next SETTLE+2 cycles       SETTLE  R = S = 0, synchronizer catches up
//     cycle PULSE_W+SETTLE+5     SAMPLE  done, match, q_sampled valid
//
//   Ports
//     Clk     system clock, rising edge
//     Resetn  asynchronous active-low reset
//     bus     rs_latch_driver_if.slave (command, latch pins, status)
// ---------------------------------------------------------------------------
module rs_latch_driver #(
    parameter int PULSE_W = 4,
    parameter int SETTLE  = 2,
    parameter int CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Resetn,
    rs_latch_driver_if.slave bus
);

    localparam int CW = $clog2(PULSE_W + SETTLE + 3);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_DRIVE  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_SAMPLE = 3'd5
    } state_t;

    state_t           state_q,       state_d;
    logic [CW-1:0]    cnt_q,         cnt_d;
    logic [1:0]       op_q,          op_d;
    logic             latch_clk_q,   latch_clk_d;
    logic             latch_r_q,     latch_r_d;
    logic             latch_s_q,     latch_s_d;
    logic             done_q,        done_d;
    logic             match_q,       match_d;
    logic             q_sampled_q,   q_sampled_d;
    logic             illegal_q,     illegal_d;
    logic [CNT_W-1:0] err_q,         err_d;
    logic             exp_q,         exp_d;
    logic             exp_valid_q,   exp_valid_d;
    logic             sync1_q,       sync1_d;
    logic             sync2_q,       sync2_d;

    logic expected;
    logic skip_cmp;
    logic accept;

    assign accept = bus.cmd_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        latch_clk_d = latch_clk_q;
        latch_r_d   = latch_r_q;
        latch_s_d   = latch_s_q;
        done_d      = 1'b0;
        match_d     = match_q;
        q_sampled_d = q_sampled_q;
        illegal_d   = 1'b0;
        err_d       = err_q;
        exp_d       = exp_q;
        exp_valid_d = exp_valid_q;
        sync1_d     = bus.latch_q;
        sync2_d     = sync1_q;

        // Expected latch state for the command in flight; a hold keeps
        // whatever the last set/reset established.
        expected = (op_q == 2'b01) ? 1'b1 :
                   (op_q == 2'b10) ? 1'b0 : exp_q;
        // A hold before any set/reset has nothing to compare against.
        skip_cmp = (op_q == 2'b00) && !exp_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.cmd_op == 2'b11) begin
                        illegal_d = 1'b1;
                    end else begin
                        op_d      = bus.cmd_op;
                        latch_r_d = bus.cmd_op[1];
                        latch_s_d = bus.cmd_op[0];
                        state_d   = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                latch_clk_d = 1'b1;
                cnt_d       = CW'(PULSE_W - 1);
                state_d     = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    latch_clk_d = 1'b0;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                latch_r_d = 1'b0;
                latch_s_d = 1'b0;
                cnt_d     = CW'(SETTLE + 1);
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    // Results are registered on entry so they are visible
                    // during the SAMPLE cycle together with done.
                    state_d     = ST_SAMPLE;
                    done_d      = 1'b1;
                    q_sampled_d = sync2_q;
                    if (skip_cmp) begin
                        match_d = 1'b1;
                    end else begin
                        match_d = (sync2_q == expected);
                        if ((sync2_q != expected) && (err_q != '1)) begin
                            err_d = err_q + 1'b1;
                        end
                    end
                    if (op_q != 2'b00) begin
                        exp_d       = expected;
                        exp_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                latch_clk_d = 1'b0;
                latch_r_d   = 1'b0;
                latch_s_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= 2'b00;
            latch_clk_q <= 1'b0;
            latch_r_q   <= 1'b0;
            latch_s_q   <= 1'b0;
            done_q      <= 1'b0;
            match_q     <= 1'b0;
            q_sampled_q <= 1'b0;
            illegal_q   <= 1'b0;
            err_q       <= '0;
            exp_q       <= 1'b0;
            exp_valid_q <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            latch_clk_q <= latch_clk_d;
            latch_r_q   <= latch_r_d;
            latch_s_q   <= latch_s_d;
            done_q      <= done_d;
            match_q     <= match_d;
            q_sampled_q <= q_sampled_d;
            illegal_q   <= illegal_d;
            err_q       <= err_d;
            exp_q       <= exp_d;
            exp_valid_q <= exp_valid_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.latch_clk = latch_clk_q;
    assign bus.latch_r   = latch_r_q;
    assign bus.latch_s   = latch_s_q;
    assign bus.done      = done_q;
    assign bus.match     = match_q;
    assign bus.q_sampled = q_sampled_q;
    assign bus.illegal   = illegal_q;
    assign bus.err_count = err_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_rs_latch_driver.sv
// ---------------------------------------------------------------------------
// tb_rs_latch_driver
//   Self-checking bench for rs_latch_driver with a behavioural gated RS
//   latch attached. The latch output can be overridden (stuck at 1 / 0).
//   A reference model tracks the latch and the expected-state bookkeeping
//   from command history and predicts match, q_sampled and err_count.
// ---------------------------------------------------------------------------
module tb_rs_latch_driver;

    localparam int PULSE_W  = 4;
    localparam int SETTLE   = 2;
    localparam int CNT_W    = 8;
    localparam int DONE_CYC = PULSE_W + SETTLE + 5;
    localparam int NREC     = 20;
    localparam int MAXERR   = (1 << CNT_W) - 1;

    logic Clk    = 1'b0;
    logic Resetn = 1'b0;

    always #5 Clk = ~Clk;

    rs_latch_driver_if #(.CNT_W(CNT_W)) ifc ();

    rs_latch_driver #(
        .PULSE_W (PULSE_W),
        .SETTLE  (SETTLE),
        .CNT_W   (CNT_W)
    ) dut (
        .Clk    (Clk),
        .Resetn (Resetn),
        .bus    (ifc.slave)
    );

    // ---------------- latch model: 0 = real latch, 1 = stuck 1, 2 = stuck 0
    logic       model_q;
    logic [1:0] mode;

    always_latch begin
        if (ifc.latch_clk) begin
            if (ifc.latch_s)      model_q <= 1'b1;
            else if (ifc.latch_r) model_q <= 1'b0;
        end
    end

    assign ifc.latch_q = (mode == 2'd1) ? 1'b1 :
                         (mode == 2'd2) ? 1'b0 : model_q;

    // ---------------- counters
    int n_cmp = 0;
    int n_err = 0;

    // ---------------- per-command recording (cycle index 1..NREC)
    logic [NREC:1]    rec_lc, rec_lr, rec_ls, rec_dn, rec_rdy, rec_ill;
    logic [CNT_W-1:0] rec_ec [0:NREC];
    int               done_cyc;
    int               n_done;
    logic             done_match;
    logic             done_qs;

    // ---------------- reference model state
    logic ref_latch;
    logic ref_latch_known = 1'b0;
    logic ref_exp;
    logic ref_exp_known;
    int   ref_err;
    logic p_match, p_qs, p_qs_known;

    task automatic ref_reset();
        ref_exp       = 1'b0;
        ref_exp_known = 1'b0;
        ref_err       = 0;
    endtask

    // Predict the outcome of one command from the command history.
    task automatic predict(input logic [1:0] op);
        logic expv;
        p_match    = 1'b1;
        p_qs       = 1'b0;
        p_qs_known = 1'b0;
        if (op == 2'b11) return;
        if (op == 2'b01) begin ref_latch = 1'b1; ref_latch_known = 1'b1; end
        if (op == 2'b10) begin ref_latch = 1'b0; ref_latch_known = 1'b1; end
        p_qs       = (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? 1'b0 : ref_latch;
        p_qs_known = (mode != 2'd0) || ref_latch_known;
        expv       = (op == 2'b01) ? 1'b1 : (op == 2'b10) ? 1'b0 : ref_exp;
        if (op == 2'b00 && !ref_exp_known) begin
            p_match = 1'b1;
        end else begin
            p_match = (p_qs == expv);
            if (!p_match && ref_err < MAXERR) ref_err = ref_err + 1;
        end
        if (op != 2'b00) begin
            ref_exp       = expv;
            ref_exp_known = 1'b1;
        end
    endtask

    task automatic do_reset();
        ifc.cmd_valid = 1'b0;
        Resetn = 1'b0;
        @(posedge Clk); #1;
        Resetn = 1'b1;
        ref_reset();
        @(posedge Clk); #1;
    endtask

    // Issue one command and record NREC cycles after the accept edge.
    task automatic run_cmd(input logic [1:0] op);
        int w = 0;
        while (!ifc.cmd_ready && w < 50) begin
            @(posedge Clk); #1;
            w++;
        end
        if (!ifc.cmd_ready) begin
            n_cmp++; n_err++;
            $display("FAIL ready_timeout: cmd_ready=%b required 1", ifc.cmd_ready);
        end
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        done_cyc = 0;
        n_done   = 0;
        for (int c = 1; c <= NREC; c++) begin
            @(posedge Clk); #1;
            if (c == 1) begin
                ifc.cmd_valid = 1'b0;
                ifc.cmd_op    = 2'($urandom_range(0, 3));
            end
            rec_lc[c]  = ifc.latch_clk;
            rec_lr[c]  = ifc.latch_r;
            rec_ls[c]  = ifc.latch_s;
            rec_dn[c]  = ifc.done;
            rec_rdy[c] = ifc.cmd_ready;
            rec_ill[c] = ifc.illegal;
            rec_ec[c]  = ifc.err_count;
            if (ifc.done) begin
                n_done++;
                done_cyc   = c;
                done_match = ifc.match;
                done_qs    = ifc.q_sampled;
            end
        end
    endtask

    // ---------------- tests
    task automatic test_reset();
        n_cmp++;
        if (ifc.cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b required 1", ifc.cmd_ready);
        end
        n_cmp++;
        if ({ifc.latch_clk, ifc.latch_r, ifc.latch_s} !== 3'b000) begin
            n_err++; $display("FAIL reset_latch_pins: got %b required 000",
                              {ifc.latch_clk, ifc.latch_r, ifc.latch_s});
        end
        n_cmp++;
        if ({ifc.done, ifc.match, ifc.q_sampled, ifc.illegal} !== 4'b0000) begin
            n_err++; $display("FAIL reset_status: got %b required 0000",
                              {ifc.done, ifc.match, ifc.q_sampled, ifc.illegal});
        end
        n_cmp++;
        if (ifc.err_count !== '0) begin
            n_err++; $display("FAIL reset_err_count: got %0d required 0", ifc.err_count);
        end
    endtask

    // Op 01 with the real latch: full waveform and result check.
    task automatic test_set_timing(input string tag);
        logic [NREC:1] e_lc, e_ls, e_dn, e_rdy;
        mode = 2'd0;
        predict(2'b01);
        run_cmd(2'b01);
        for (int c = 1; c <= NREC; c++) begin
            e_lc[c]  = (c >= 2) && (c <= PULSE_W + 1);
            e_ls[c]  = (c <= PULSE_W + 2);
            e_dn[c]  = (c == DONE_CYC);
            e_rdy[c] = (c > DONE_CYC);
        end
        n_cmp++;
        if (rec_lc !== e_lc) begin
            n_err++; $display("FAIL %s latch_clk: got %b required %b", tag, rec_lc, e_lc);
        end
        n_cmp++;
        if (rec_ls !== e_ls) begin
            n_err++; $display("FAIL %s latch_s: got %b required %b", tag, rec_ls, e_ls);
        end
        n_cmp++;
        if (rec_lr !== '0) begin
            n_err++; $display("FAIL %s latch_r: got %b required all 0", tag, rec_lr);
        end
        n_cmp++;
        if (rec_dn !== e_dn) begin
            n_err++; $display("FAIL %s done: got %b required %b", tag, rec_dn, e_dn);
        end
        n_cmp++;
        if (rec_rdy !== e_rdy) begin
            n_err++; $display("FAIL %s cmd_ready: got %b required %b", tag, rec_rdy, e_rdy);
        end
        n_cmp++;
        if (done_match !== 1'b1 || done_qs !== 1'b1) begin
            n_err++; $display("FAIL %s result: match=%b q_sampled=%b required 1 1",
                              tag, done_match, done_qs);
        end
        n_cmp++;
        if (rec_ec[DONE_CYC+1] !== CNT_W'(ref_err)) begin
            n_err++; $display("FAIL %s err_count: got %0d required %0d",
                              tag, rec_ec[DONE_CYC+1], ref_err);
        end
    endtask

    task automatic test_sequence();
        logic [1:0] ops [3];
        logic       qs_req [3];
        ops = '{2'b01, 2'b10, 2'b00};
        qs_req = '{1'b1, 1'b0, 1'b0};
        mode = 2'd0;
        for (int i = 0; i < 3; i++) begin
            predict(ops[i]);
            run_cmd(ops[i]);
            n_cmp++;
            if (done_cyc != DONE_CYC || n_done != 1) begin
                n_err++; $display("FAIL seq%0d done: cycle %0d count %0d required cycle %0d count 1",
                                  i, done_cyc, n_done, DONE_CYC);
            end
            n_cmp++;
            if (done_match !== 1'b1 || done_qs !== qs_req[i]) begin
                n_err++; $display("FAIL seq%0d result: match=%b q_sampled=%b required 1 %b",
                                  i, done_match, done_qs, qs_req[i]);
            end
            n_cmp++;
            if (rec_ec[DONE_CYC+1] !== '0) begin
                n_err++; $display("FAIL seq%0d err_count: got %0d required 0",
                                  i, rec_ec[DONE_CYC+1]);
            end
        end
    endtask

    task automatic test_hold_after_reset();
        do_reset();
        mode = 2'd1;
        predict(2'b00);
        run_cmd(2'b00);
        n_cmp++;
        if (done_cyc != DONE_CYC) begin
            n_err++; $display("FAIL hold_nexp done_cycle: got %0d required %0d", done_cyc, DONE_CYC);
        end
        n_cmp++;
        if (done_match !== 1'b1 || done_qs !== 1'b1) begin
            n_err++; $display("FAIL hold_nexp result: match=%b q_sampled=%b required 1 1",
                              done_match, done_qs);
        end
        n_cmp++;
        if (rec_ec[DONE_CYC+1] !== '0) begin
            n_err++; $display("FAIL hold_nexp err_count: got %0d required 0", rec_ec[DONE_CYC+1]);
        end
        mode = 2'd0;
    endtask

    task automatic test_illegal();
        logic [NREC:1] e_ill;
        mode = 2'd0;
        predict(2'b11);
        run_cmd(2'b11);
        e_ill = '0;
        e_ill[1] = 1'b1;
        n_cmp++;
        if (rec_ill !== e_ill) begin
            n_err++; $display("FAIL illegal_pulse: got %b required %b", rec_ill, e_ill);
        end
        n_cmp++;
        if ((rec_lc | rec_lr | rec_ls | rec_dn) !== '0) begin
            n_err++; $display("FAIL illegal_quiet: clk=%b r=%b s=%b done=%b required all 0",
                              rec_lc, rec_lr, rec_ls, rec_dn);
        end
        n_cmp++;
        if (rec_rdy !== '1) begin
            n_err++; $display("FAIL illegal_ready: got %b required all 1", rec_rdy);
        end
        n_cmp++;
        if (rec_ec[NREC] !== CNT_W'(ref_err)) begin
            n_err++; $display("FAIL illegal_err_count: got %0d required %0d", rec_ec[NREC], ref_err);
        end
        test_set_timing("after_illegal");
    endtask

    task automatic test_reset_abort();
        int seen_done = 0;
        mode = 2'd0;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = 2'b01;
        @(posedge Clk); #1;
        ifc.cmd_valid = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        n_cmp++;
        if (ifc.latch_clk !== 1'b1 || ifc.latch_s !== 1'b1) begin
            n_err++; $display("FAIL abort_pre: latch_clk=%b latch_s=%b required 1 1",
                              ifc.latch_clk, ifc.latch_s);
        end
        // The gate was high with S=1, so the latch now holds 1.
        ref_latch = 1'b1;
        ref_latch_known = 1'b1;
        Resetn = 1'b0;
        #1;
        n_cmp++;
        if (ifc.latch_clk !== 1'b0 || ifc.latch_s !== 1'b0) begin
            n_err++; $display("FAIL abort_async_drop: latch_clk=%b latch_s=%b required 0 0",
                              ifc.latch_clk, ifc.latch_s);
        end
        n_cmp++;
        if (ifc.cmd_ready !== 1'b1 || ifc.err_count !== '0 || ifc.done !== 1'b0) begin
            n_err++; $display("FAIL abort_status: ready=%b err=%0d done=%b required 1 0 0",
                              ifc.cmd_ready, ifc.err_count, ifc.done);
        end
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Resetn = 1'b1;
        ref_reset();
        for (int c = 0; c < 12; c++) begin
            @(posedge Clk); #1;
            if (ifc.done) seen_done++;
        end
        n_cmp++;
        if (seen_done != 0) begin
            n_err++; $display("FAIL abort_no_done: got %0d done pulses required 0", seen_done);
        end
        test_set_timing("after_abort");
    endtask

    task automatic test_stuck_saturate();
        do_reset();
        mode = 2'd2;
        for (int i = 0; i < 300; i++) begin
            predict(2'b01);
            run_cmd(2'b01);
            n_cmp++;
            if (n_done != 1 || done_match !== 1'b0) begin
                n_err++; $display("FAIL stuck%0d match: done_count=%0d match=%b required 1 0",
                                  i, n_done, done_match);
            end
            n_cmp++;
            if (rec_ec[DONE_CYC+1] !== CNT_W'(ref_err)) begin
                n_err++; $display("FAIL stuck%0d err_count: got %0d required %0d",
                                  i, rec_ec[DONE_CYC+1], ref_err);
            end
            if (i == 0) begin
                n_cmp++;
                if (rec_ec[DONE_CYC+1] !== CNT_W'(1)) begin
                    n_err++; $display("FAIL stuck_first err_count: got %0d required 1",
                                      rec_ec[DONE_CYC+1]);
                end
            end
        end
        n_cmp++;
        if (ifc.err_count !== CNT_W'(MAXERR)) begin
            n_err++; $display("FAIL stuck_saturated err_count: got %0d required %0d",
                              ifc.err_count, MAXERR);
        end
        mode = 2'd0;
    endtask

    task automatic test_random();
        logic [1:0] op;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) begin @(posedge Clk); #1; end
            op = 2'($urandom_range(0, 3));
            predict(op);
            run_cmd(op);
            n_cmp++;
            if ((rec_lr & rec_ls) !== '0) begin
                n_err++; $display("FAIL rnd%0d r_and_s: r=%b s=%b required never both", i, rec_lr, rec_ls);
            end
            if (op == 2'b11) begin
                n_cmp++;
                if (n_done != 0 || rec_ill[1] !== 1'b1) begin
                    n_err++; $display("FAIL rnd%0d illegal: done_count=%0d illegal=%b required 0 1",
                                      i, n_done, rec_ill[1]);
                end
            end else begin
                n_cmp++;
                if (done_cyc != DONE_CYC || n_done != 1) begin
                    n_err++; $display("FAIL rnd%0d done: cycle %0d count %0d required %0d 1",
                                      i, done_cyc, n_done, DONE_CYC);
                end
                n_cmp++;
                if (done_match !== p_match) begin
                    n_err++; $display("FAIL rnd%0d match: got %b required %b op %b mode %0d",
                                      i, done_match, p_match, op, mode);
                end
                if (p_qs_known) begin
                    n_cmp++;
                    if (done_qs !== p_qs) begin
                        n_err++; $display("FAIL rnd%0d q_sampled: got %b required %b", i, done_qs, p_qs);
                    end
                end
            end
            n_cmp++;
            if (rec_ec[NREC] !== CNT_W'(ref_err)) begin
                n_err++; $display("FAIL rnd%0d err_count: got %0d required %0d", i, rec_ec[NREC], ref_err);
            end
        end
    endtask

    initial begin
        mode          = 2'd0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = 2'b00;
        Resetn        = 1'b0;
        ref_reset();
        repeat (3) @(posedge Clk);
        #1;
        test_reset();
        Resetn = 1'b1;
        @(posedge Clk); #1;
        test_set_timing("set_first");
        test_sequence();
        test_hold_after_reset();
        test_illegal();
        test_reset_abort();
        test_stuck_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
